// File: rtl/add_tree_acc.sv
`default_nettype none
//==============================================================================
//  Module   : add_tree_acc
//  Purpose  : Sums NUM_IN unsigned lanes per beat through a registered
//             pairwise adder tree, then accumulates the per-beat sums over a
//             block framed by first/last flags. One block total is emitted
//             per block, with a valid/ready handshake and a sticky overflow
//             flag (saturating or wrapping, selected by SATURATE).
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
//  Ports
//    clk          in   1                   clock, rising edge
//    rst          in   1                   asynchronous reset, active high
//    in_valid     in   1                   beat present on in_data
//    in_ready     out  1                   beat accepted when valid && ready
//    in_first     in   1                   beat starts a block
//    in_last      in   1                   beat ends a block
//    in_data      in   NUM_IN*BIT_WIDTH    lane k = [k*BIT_WIDTH +: BIT_WIDTH]
//    out_valid    out  1                   out_sum/out_overflow hold a result
//    out_ready    in   1                   downstream accepts the result
//    out_sum      out  ACC_WIDTH           block total
//    out_overflow out  1                   block total exceeded 2^ACC_WIDTH-1
//------------------------------------------------------------------------------
//  Parameters: NUM_IN must be a power of two in 2..16, and ACC_WIDTH must be
//  at least BIT_WIDTH + log2(NUM_IN) so the tree sum always fits.
//==============================================================================
module add_tree_acc #(
   parameter int BIT_WIDTH = 14,
   parameter int NUM_IN    = 4,
   parameter int ACC_WIDTH = 20,
   parameter int SATURATE  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_first,
   input  logic                          in_last,
   input  logic [NUM_IN*BIT_WIDTH-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_WIDTH-1:0]          out_sum,
   output logic                          out_overflow
);

   localparam int LOG2  = $clog2(NUM_IN);
   localparam int SUM_W = BIT_WIDTH + LOG2;
   localparam int NODES = 2 * NUM_IN;

   // Single stall condition for the whole pipeline: everything advances
   // unless a finished result is waiting on a stalled consumer.
   logic en;

   // Tree stored heap-style: node[1] is the root, node[i] = node[2i] +
   // node[2i+1], leaves are node[NUM_IN .. 2*NUM_IN-1]. Every node is a
   // register, so a node at depth d lands LOG2-d edges after acceptance.
   // All nodes share the final width; upper bits of shallow levels are
   // constant zero and are trimmed by synthesis.
   logic [SUM_W-1:0] node [1:NODES-1];

   // Side-band flags travelling with the tree; index LOG2 aligns with root.
   logic [LOG2:0] vld;
   logic [LOG2:0] fst;
   logic [LOG2:0] lst;

   logic                 in_block;   // a block is open (last not yet seen)
   logic [ACC_WIDTH-1:0] acc;
   logic                 acc_ovf;

   logic                 start;
   logic [ACC_WIDTH:0]   base_ext;
   logic [ACC_WIDTH:0]   tree_ext;
   logic [ACC_WIDTH:0]   sum_ext;
   logic                 carry;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 ovf_next;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   //---------------------------------------------------------------------------
   // Adder tree and side-band pipeline
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NODES; i++) begin
            node[i] <= '0;
         end
         vld <= '0;
         fst <= '0;
         lst <= '0;
      end else if (en) begin
         for (int k = 0; k < NUM_IN; k++) begin
            node[NUM_IN + k] <= SUM_W'(in_data[k*BIT_WIDTH +: BIT_WIDTH]);
         end
         for (int i = 1; i < NUM_IN; i++) begin
            node[i] <= node[2*i] + node[2*i + 1];
         end
         vld <= {vld[LOG2-1:0], in_valid};
         fst <= {fst[LOG2-1:0], in_first};
         lst <= {lst[LOG2-1:0], in_last};
      end
   end

   //---------------------------------------------------------------------------
   // Accumulate step. A beat starts a block when flagged first or when no
   // block is open (after a last beat or after reset); starting drops any
   // partial total, which is how an aborted block disappears silently.
   //---------------------------------------------------------------------------
   always_comb begin
      start    = fst[LOG2] || !in_block;
      base_ext = start ? '0 : {1'b0, acc};
      tree_ext = (ACC_WIDTH+1)'(node[1]);
      sum_ext  = base_ext + tree_ext;
      carry    = sum_ext[ACC_WIDTH];
      // Once clamped at all-ones, any further non-negative addend either
      // carries again or adds zero, so the clamp holds for the whole block.
      acc_next = (carry && (SATURATE != 0)) ? '1 : sum_ext[ACC_WIDTH-1:0];
      ovf_next = (!start && acc_ovf) || carry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         acc_ovf      <= 1'b0;
         in_block     <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
      end else if (en) begin
         if (vld[LOG2]) begin
            acc      <= acc_next;
            acc_ovf  <= ovf_next;
            in_block <= !lst[LOG2];
         end
         // With en high the current result (if any) is being taken, so
         // out_valid simply follows whether a new result loads now.
         if (vld[LOG2] && lst[LOG2]) begin
            out_valid    <= 1'b1;
            out_sum      <= acc_next;
            out_overflow <= ovf_next;
         end else begin
            out_valid    <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_add_tree_acc.sv
`default_nettype none
//==============================================================================
//  Module   : tb_add_tree_acc
//  Purpose  : Self-checking bench for add_tree_acc. Three instances: default
//             saturating (a), wrapping (b, same stimulus as a) and a 16-lane
//             8-bit 12-bit-accumulator instance (c). A transaction-level
//             model turns accepted beats into expected block totals.
//  Revision : 1.0  initial release
//==============================================================================
module tb_add_tree_acc;

   logic clk = 1'b0;
   logic rst;

   // shared stimulus for a and b
   logic        in_valid, in_first, in_last, out_ready;
   logic [55:0] din;
   logic        a_in_ready, a_out_valid, a_out_overflow;
   logic [19:0] a_out_sum;
   logic        b_in_ready, b_out_valid, b_out_overflow;
   logic [19:0] b_out_sum;

   // 16-lane instance
   logic         c_in_valid, c_in_first, c_in_last, c_out_ready;
   logic [127:0] c_din;
   logic         c_in_ready, c_out_valid, c_out_overflow;
   logic [11:0]  c_out_sum;

   int n_chk = 0;
   int n_err = 0;

   longint qa[$];
   longint qb[$];
   longint qc[$];
   longint tot_ab = 0;
   longint tot_c  = 0;
   bit     open_ab = 1'b0;
   bit     open_c  = 1'b0;

   bit          a_held = 1'b0, b_held = 1'b0, c_held = 1'b0;
   logic [20:0] a_hold_val, b_hold_val;
   logic [12:0] c_hold_val;

   add_tree_acc #(.BIT_WIDTH(14), .NUM_IN(4), .ACC_WIDTH(20), .SATURATE(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_first(in_first), .in_last(in_last), .in_data(din),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_sum(a_out_sum), .out_overflow(a_out_overflow));

   add_tree_acc #(.BIT_WIDTH(14), .NUM_IN(4), .ACC_WIDTH(20), .SATURATE(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_first(in_first), .in_last(in_last), .in_data(din),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_sum(b_out_sum), .out_overflow(b_out_overflow));

   add_tree_acc #(.BIT_WIDTH(8), .NUM_IN(16), .ACC_WIDTH(12), .SATURATE(1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_first(c_in_first), .in_last(c_in_last), .in_data(c_din),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sum(c_out_sum), .out_overflow(c_out_overflow));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Block total as the output should present it: clamped or wrapped.
   function automatic longint exp_sum(input longint tot, input int sat, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      if (tot > mx) return (sat != 0) ? mx : (tot & mx);
      return tot;
   endfunction

   function automatic logic [55:0] rep14(input logic [13:0] v);
      return {4{v}};
   endfunction

   function automatic logic [127:0] rep8(input logic [7:0] v);
      return {16{v}};
   endfunction

   //---------------------------------------------------------------------------
   // Input-side model: each accepted beat adds its lane total to the running
   // true block total; a last beat queues the total for each instance.
   // Sampled on the falling edge, i.e. the transfer happens at the next rise.
   //---------------------------------------------------------------------------
   always @(negedge clk) begin
      longint s;
      if (!rst) begin
         check_val("a_in_ready", a_in_ready, !a_out_valid || out_ready);
         check_val("b_in_ready", b_in_ready, !b_out_valid || out_ready);
         if (in_valid && a_in_ready) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += longint'(din[k*14 +: 14]);
            if (in_first || !open_ab) tot_ab = 0;
            tot_ab += s;
            open_ab = !in_last;
            if (in_last) begin
               qa.push_back(tot_ab);
               qb.push_back(tot_ab);
            end
         end
      end
   end

   always @(negedge clk) begin
      longint s;
      if (!rst) begin
         check_val("c_in_ready", c_in_ready, !c_out_valid || c_out_ready);
         if (c_in_valid && c_in_ready) begin
            s = 0;
            for (int k = 0; k < 16; k++) s += longint'(c_din[k*8 +: 8]);
            if (c_in_first || !open_c) tot_c = 0;
            tot_c += s;
            open_c = !c_in_last;
            if (c_in_last) qc.push_back(tot_c);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Output-side scoreboards with hold-while-stalled checks.
   //---------------------------------------------------------------------------
   always @(negedge clk) begin
      longint t;
      if (rst) a_held = 1'b0;
      else begin
         if (a_held) check_val("a_hold", {a_out_valid, a_out_overflow, a_out_sum}, {1'b1, a_hold_val});
         a_held     = a_out_valid && !out_ready;
         a_hold_val = {a_out_overflow, a_out_sum};
         if (a_out_valid && out_ready) begin
            check_val("a_result_expected", qa.size() > 0, 1);
            if (qa.size() > 0) begin
               t = qa.pop_front();
               check_val("a_sum", a_out_sum, exp_sum(t, 1, 20));
               check_val("a_ovf", a_out_overflow, t > 64'd1048575);
            end
         end
      end
   end

   always @(negedge clk) begin
      longint t;
      if (rst) b_held = 1'b0;
      else begin
         if (b_held) check_val("b_hold", {b_out_valid, b_out_overflow, b_out_sum}, {1'b1, b_hold_val});
         b_held     = b_out_valid && !out_ready;
         b_hold_val = {b_out_overflow, b_out_sum};
         if (b_out_valid && out_ready) begin
            check_val("b_result_expected", qb.size() > 0, 1);
            if (qb.size() > 0) begin
               t = qb.pop_front();
               check_val("b_sum", b_out_sum, exp_sum(t, 0, 20));
               check_val("b_ovf", b_out_overflow, t > 64'd1048575);
            end
         end
      end
   end

   always @(negedge clk) begin
      longint t;
      if (rst) c_held = 1'b0;
      else begin
         if (c_held) check_val("c_hold", {c_out_valid, c_out_overflow, c_out_sum}, {1'b1, c_hold_val});
         c_held     = c_out_valid && !c_out_ready;
         c_hold_val = {c_out_overflow, c_out_sum};
         if (c_out_valid && c_out_ready) begin
            check_val("c_result_expected", qc.size() > 0, 1);
            if (qc.size() > 0) begin
               t = qc.pop_front();
               check_val("c_sum", c_out_sum, exp_sum(t, 1, 12));
               check_val("c_ovf", c_out_overflow, t > 64'd4095);
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus tasks; all are entered and left 1 ns after a rising edge.
   //---------------------------------------------------------------------------
   task automatic do_reset(input int cycles);
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      c_in_valid = 1'b0;
      qa.delete(); qb.delete(); qc.delete();
      open_ab = 1'b0;
      open_c  = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         check_val("rst_a_out", {a_out_valid, a_out_overflow, a_out_sum}, 0);
         check_val("rst_b_out", {b_out_valid, b_out_overflow, b_out_sum}, 0);
         check_val("rst_c_out", {c_out_valid, c_out_overflow, c_out_sum}, 0);
         check_val("rst_in_ready", {a_in_ready, c_in_ready}, 2'b11);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_ab(input logic [55:0] d, input logic f, input logic l);
      bit ok;
      int n;
      in_valid = 1'b1; din = d; in_first = f; in_last = l;
      ok = 1'b0; n = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = a_in_ready;
         @(posedge clk); #1;
         n++;
      end
      check_val("send_ab_accepted", ok, 1);
   endtask

   task automatic send_c(input logic [127:0] d, input logic f, input logic l);
      bit ok;
      int n;
      c_in_valid = 1'b1; c_din = d; c_in_first = f; c_in_last = l;
      ok = 1'b0; n = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = c_in_ready;
         @(posedge clk); #1;
         n++;
      end
      check_val("send_c_accepted", ok, 1);
   endtask

   task automatic wait_res_ab(output logic [19:0] sa, output logic oa,
                              output logic [19:0] sb, output logic ob);
      int n;
      n = 0;
      @(negedge clk);
      while (!a_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("result_ab_arrived", n < 50, 1);
      sa = a_out_sum; oa = a_out_overflow;
      sb = b_out_sum; ob = b_out_overflow;
      @(posedge clk); #1;
   endtask

   //---------------------------------------------------------------------------
   initial begin
      logic [19:0] sa, sb;
      logic        oa, ob;
      int          lat, n;
      bit          big;

      rst = 1'b1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din = '0; out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_first = 1'b0; c_in_last = 1'b0; c_din = '0; c_out_ready = 1'b1;
      do_reset(3);

      // one full-scale one-beat block, latency LOG2+1 = 3
      send_ab(rep14(14'd16383), 1'b1, 1'b1);
      in_valid = 1'b0;
      lat = 0;
      while (!a_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("t1_latency", lat, 3);
      check_val("t1_sum", a_out_sum, 65532);
      check_val("t1_ovf", a_out_overflow, 0);
      @(posedge clk); #1;
      check_val("t1_single_cycle", a_out_valid, 0);

      // 4-beat block, lanes 1,2,3,4
      send_ab(rep14(14'd1), 1'b1, 1'b0);
      send_ab(rep14(14'd2), 1'b0, 1'b0);
      send_ab(rep14(14'd3), 1'b0, 1'b0);
      send_ab(rep14(14'd4), 1'b0, 1'b1);
      in_valid = 1'b0;
      wait_res_ab(sa, oa, sb, ob);
      check_val("t2_sum", sa, 40);
      check_val("t2_ovf", oa, 0);

      // 17 full-scale beats: clamp versus wrap, then a small block
      for (int i = 0; i < 17; i++) send_ab(rep14(14'd16383), i == 0, i == 16);
      in_valid = 1'b0;
      wait_res_ab(sa, oa, sb, ob);
      check_val("t3_sat_sum", sa, 1048575);
      check_val("t3_sat_ovf", oa, 1);
      check_val("t3_wrap_sum", sb, 65468);
      check_val("t3_wrap_ovf", ob, 1);
      send_ab(rep14(14'd1), 1'b1, 1'b1);
      in_valid = 1'b0;
      wait_res_ab(sa, oa, sb, ob);
      check_val("t3_next_sum", sa, 4);
      check_val("t3_next_ovf", {oa, ob}, 0);

      // back-to-back one-beat blocks with a 5-cycle downstream stall
      fork
         begin
            for (int k = 1; k <= 10; k++) send_ab(rep14(14'(k)), 1'b1, 1'b1);
            in_valid = 1'b0;
         end
         begin
            int m;
            m = 0;
            @(negedge clk);
            while (!a_out_valid && m < 50) begin
               @(negedge clk);
               m++;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check_val("t4_stall_in_ready", {a_out_valid, a_in_ready}, 2'b10);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      n = 0;
      while ((qa.size() != 0 || a_out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("t4_all_emitted", qa.size() + qb.size(), 0);

      // aborted block, then reset mid-block
      send_ab(rep14(14'd5), 1'b1, 1'b0);
      send_ab(rep14(14'd5), 1'b0, 1'b0);
      send_ab(rep14(14'd1), 1'b1, 1'b1);
      in_valid = 1'b0;
      wait_res_ab(sa, oa, sb, ob);
      check_val("t5_abort_sum", sa, 4);
      send_ab(rep14(14'd5), 1'b1, 1'b0);
      send_ab(rep14(14'd5), 1'b0, 1'b0);
      in_valid = 1'b0;
      do_reset(3);
      send_ab(rep14(14'd2), 1'b0, 1'b1);
      in_valid = 1'b0;
      wait_res_ab(sa, oa, sb, ob);
      check_val("t5_post_reset_sum", sa, 8);
      check_val("t5_post_reset_ovf", oa, 0);

      // randomized traffic: small lanes with short blocks, then near-full
      // lanes with long blocks so both overflow modes are exercised
      for (int i = 0; i < 800; i++) begin
         big       = ((i / 200) % 2) == 1;
         in_valid  = ($urandom % 4) != 0;
         in_first  = ($urandom % 12) == 0;
         in_last   = ($urandom % (big ? 24 : 4)) == 0;
         for (int k = 0; k < 4; k++)
            din[k*14 +: 14] = big ? 14'(16383 - ($urandom % 8)) : 14'($urandom);
         out_ready = ($urandom % 4) != 0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check_val("rand_ab_drained", qa.size() + qb.size(), 0);

      // 16-lane instance: latency LOG2+1 = 5
      send_c(rep8(8'd255), 1'b1, 1'b1);
      c_in_valid = 1'b0;
      lat = 0;
      while (!c_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("t6_latency", lat, 5);
      check_val("t6_sum", c_out_sum, 4080);
      check_val("t6_ovf", c_out_overflow, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 400; i++) begin
         c_in_valid  = ($urandom % 4) != 0;
         c_in_first  = ($urandom % 10) == 0;
         c_in_last   = ($urandom % 3) == 0;
         for (int k = 0; k < 16; k++) c_din[k*8 +: 8] = 8'($urandom);
         c_out_ready = ($urandom % 3) != 0;
         @(posedge clk); #1;
      end
      c_in_valid = 1'b0;
      c_out_ready = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      check_val("rand_c_drained", qc.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
